// File: rtl/e1_clk_tune_ctrl_pkg.sv
// Shared types and constants for the E1 clock-tune loop.
// FSM encoding, tune word width and midscale reset value.
package e1_clk_tune_ctrl_pkg;

   localparam int          TUNE_W   = 24;
   localparam logic [23:0] TUNE_MID = 24'h800000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ERR   = 2'd1,
      ST_INTEG = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/e1_clk_tune_ctrl_sat_add.sv
// Unsigned 24-bit value plus a left-shifted signed error,
// clamped to [0, 24'hFFFFFF] with a wide intermediate so nothing wraps.
module sat_add_u24 (
   input  logic        [23:0] base,
   input  logic signed [15:0] err,
   input  logic        [3:0]  sh,
   output logic        [23:0] sum
);

   logic signed [41:0] ext_err;
   logic signed [41:0] ext_sum;

   // widen, shift, add, then clamp to the unsigned 24-bit range
   always_comb begin
      ext_err = $signed({{26{err[15]}}, err}) <<< sh;
      ext_sum = $signed({18'b0, base}) + ext_err;
      if (ext_sum < 0)
         sum = '0;
      else if (ext_sum > 42'sh0FFFFFF)
         sum = '1;
      else
         sum = ext_sum[23:0];
   end

endmodule

// File: rtl/e1_clk_tune_ctrl.sv
// Closed-loop PI controller driving the coarse/fine clock-tune PDMs
// from the E1 tick count captured at each USB SOF.
module e1_clk_tune_ctrl
   import e1_clk_tune_ctrl_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int NOMINAL  = 2048,
   parameter int ERR_MAX  = 255,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_CNT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cap_val,
   input  logic             cap_stb,
   input  logic             ctl_en,
   input  logic [3:0]       ctl_kp_sh,
   input  logic [3:0]       ctl_ki_sh,
   input  logic [23:0]      ctl_preset,
   input  logic             ctl_preset_stb,
   output logic [11:0]      pdm_hi_val,
   output logic [11:0]      pdm_lo_val,
   output logic             pdm_oe,
   output logic             locked,
   output logic [15:0]      err_last,
   output logic             sample_miss
);

   localparam int               LCW   = $clog2(LOCK_CNT + 1);
   localparam logic [LCW-1:0]   LC_MX = LCW'(LOCK_CNT);
   localparam logic [CNT_W-1:0] NOM_C = CNT_W'(NOMINAL);

   state_t             state, state_nxt;
   logic               prime;
   logic [CNT_W-1:0]   cap_q;
   logic signed [15:0] err_q;
   logic [23:0]        integ, tune;
   logic [23:0]        integ_sum, tune_sum;
   logic [LCW-1:0]     lock_cnt, lock_nxt;
   logic signed [CNT_W:0] e_raw;
   logic signed [15:0] e_clamp;
   logic               in_lock;
   logic               start, miss;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // sequencing; enable drop and preset abort to IDLE
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cap_stb && ctl_en && prime) begin
               state_nxt = ST_ERR;
               start     = 1'b1;
            end
         end
         ST_ERR:   state_nxt = ST_INTEG;
         ST_INTEG: state_nxt = ST_OUT;
         ST_OUT:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (!ctl_en || ctl_preset_stb) begin
         state_nxt = ST_IDLE;
         start     = 1'b0;
      end
      miss = cap_stb && ctl_en && !ctl_preset_stb &&
             (!prime || state != ST_IDLE);
   end

   // clamped error and lock-counter step
   always_comb begin
      e_raw = $signed({1'b0, NOM_C}) - $signed({1'b0, cap_q});
      if (e_raw > $signed(ERR_MAX))
         e_clamp = 16'(ERR_MAX);
      else if (e_raw < -$signed(ERR_MAX))
         e_clamp = -16'(ERR_MAX);
      else
         e_clamp = 16'(e_raw);
      in_lock = (err_q >= -LOCK_TOL) && (err_q <= LOCK_TOL);
      if (!in_lock)
         lock_nxt = '0;
      else if (lock_cnt == LC_MX)
         lock_nxt = LC_MX;
      else
         lock_nxt = lock_cnt + 1'b1;
   end

   sat_add_u24 u_integ_add (
      .base (integ),
      .err  (err_q),
      .sh   (ctl_ki_sh),
      .sum  (integ_sum)
   );

   sat_add_u24 u_tune_add (
      .base (integ),
      .err  (err_q),
      .sh   (ctl_kp_sh),
      .sum  (tune_sum)
   );

   // datapath registers: capture, error, integrator, tune, lock
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prime       <= 1'b0;
         cap_q       <= '0;
         err_q       <= '0;
         integ       <= TUNE_MID;
         tune        <= TUNE_MID;
         lock_cnt    <= '0;
         locked      <= 1'b0;
         pdm_oe      <= 1'b0;
         sample_miss <= 1'b0;
      end else begin
         pdm_oe      <= ctl_en;
         sample_miss <= miss;
         if (!ctl_en)
            prime <= 1'b0;
         else if (cap_stb && !ctl_preset_stb)
            prime <= 1'b1;
         if (start)
            cap_q <= cap_val;
         if (ctl_preset_stb) begin
            integ    <= ctl_preset;
            tune     <= ctl_preset;
            lock_cnt <= '0;
            locked   <= 1'b0;
         end else if (!ctl_en) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
         end else begin
            unique case (state)
               ST_ERR:   err_q <= e_clamp;
               ST_INTEG: integ <= integ_sum;
               ST_OUT: begin
                  tune     <= tune_sum;
                  lock_cnt <= lock_nxt;
                  locked   <= (lock_nxt == LC_MX);
               end
               default: ;
            endcase
         end
      end
   end

   assign pdm_hi_val = tune[23:12];
   assign pdm_lo_val = tune[11:0];
   assign err_last   = err_q;

endmodule

// File: tb/tb_e1_clk_tune_ctrl.sv
// Self-checking bench for e1_clk_tune_ctrl.
// Randomized samples checked against a per-sample PI reference model.
module tb_e1_clk_tune_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cap_val;
   logic        cap_stb;
   logic        ctl_en;
   logic [3:0]  ctl_kp_sh;
   logic [3:0]  ctl_ki_sh;
   logic [23:0] ctl_preset;
   logic        ctl_preset_stb;
   logic [11:0] pdm_hi_val;
   logic [11:0] pdm_lo_val;
   logic        pdm_oe;
   logic        locked;
   logic [15:0] err_last;
   logic        sample_miss;

   int total = 0;
   int bad   = 0;

   longint m_integ, m_tune;
   int     m_cnt, m_err;

   e1_clk_tune_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .cap_val        (cap_val),
      .cap_stb        (cap_stb),
      .ctl_en         (ctl_en),
      .ctl_kp_sh      (ctl_kp_sh),
      .ctl_ki_sh      (ctl_ki_sh),
      .ctl_preset     (ctl_preset),
      .ctl_preset_stb (ctl_preset_stb),
      .pdm_hi_val     (pdm_hi_val),
      .pdm_lo_val     (pdm_lo_val),
      .pdm_oe         (pdm_oe),
      .locked         (locked),
      .err_last       (err_last),
      .sample_miss    (sample_miss)
   );

   always #5 clk = ~clk;

   function automatic longint sat24(input longint v);
      if (v < 0) return 0;
      if (v > 64'hFFFFFF) return 64'hFFFFFF;
      return v;
   endfunction

   // one processed sample of the PI loop, from the rules
   task automatic model_sample(input int cap);
      int e;
      e = 2048 - cap;
      if (e > 255) e = 255;
      if (e < -255) e = -255;
      m_err   = e;
      m_integ = sat24(m_integ + longint'(e) * (longint'(1) << ctl_ki_sh));
      m_tune  = sat24(m_integ + longint'(e) * (longint'(1) << ctl_kp_sh));
      if (e >= -2 && e <= 2) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
      else m_cnt = 0;
   endtask

   task automatic model_reset();
      m_integ = 64'h800000;
      m_tune  = 64'h800000;
      m_cnt   = 0;
      m_err   = 0;
   endtask

   // returns half a cycle after the sampling edge
   task automatic strobe(input int cap);
      @(negedge clk);
      cap_val = 16'(cap);
      cap_stb = 1'b1;
      @(negedge clk);
      cap_stb = 1'b0;
   endtask

   // returns half a cycle after the tune update edge
   task automatic sample(input int cap);
      strobe(cap);
      repeat (3) @(negedge clk);
      model_sample(cap);
   endtask

   task automatic do_preset(input logic [23:0] v);
      @(negedge clk);
      ctl_preset     = v;
      ctl_preset_stb = 1'b1;
      @(negedge clk);
      ctl_preset_stb = 1'b0;
      m_integ = longint'(v);
      m_tune  = longint'(v);
      m_cnt   = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cap_val = '0; cap_stb = 1'b0; ctl_en = 1'b0;
      ctl_kp_sh = '0; ctl_ki_sh = '0;
      ctl_preset = '0; ctl_preset_stb = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'h800000) begin
         bad++;
         $display("FAIL reset_tune got %h want 800000", {pdm_hi_val, pdm_lo_val});
      end
      total++;
      if (pdm_oe !== 1'b0) begin
         bad++; $display("FAIL reset_oe got %b want 0", pdm_oe);
      end
      total++;
      if (locked !== 1'b0) begin
         bad++; $display("FAIL reset_locked got %b want 0", locked);
      end
      total++;
      if (err_last !== 16'h0) begin
         bad++; $display("FAIL reset_err got %h want 0", err_last);
      end
      total++;
      if (sample_miss !== 1'b0) begin
         bad++; $display("FAIL reset_miss got %b want 0", sample_miss);
      end
      rst = 1'b0;
   endtask

   task automatic test_lock_nominal();
      ctl_kp_sh = 4'($urandom_range(0, 4));
      ctl_ki_sh = 4'($urandom_range(0, 4));
      @(negedge clk);
      ctl_en = 1'b1;
      @(negedge clk);
      total++;
      if (pdm_oe !== 1'b1) begin
         bad++; $display("FAIL en_oe got %b want 1", pdm_oe);
      end
      strobe(2048);
      total++;
      if (sample_miss !== 1'b1) begin
         bad++; $display("FAIL prime_miss got %b want 1", sample_miss);
      end
      @(negedge clk);
      total++;
      if (sample_miss !== 1'b0) begin
         bad++; $display("FAIL prime_miss_len got %b want 0", sample_miss);
      end
      for (int i = 0; i < 19; i++) begin
         sample(2048);
         total++;
         if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune) ||
             locked !== (m_cnt == 16)) begin
            bad++;
            $display("FAIL nominal_%0d got tune %h lock %b want %h %b",
                     i, {pdm_hi_val, pdm_lo_val}, locked,
                     24'(m_tune), (m_cnt == 16));
         end
      end
   endtask

   task automatic test_integ_step();
      do_preset(24'h800000);
      ctl_kp_sh = 4'd0;
      ctl_ki_sh = 4'd4;
      for (int k = 0; k < 2; k++) begin
         strobe(2040);
         total++;
         if (sample_miss !== 1'b0) begin
            bad++; $display("FAIL step_miss_%0d got %b want 0", k, sample_miss);
         end
         @(negedge clk);
         total++;
         if (err_last !== 16'd8) begin
            bad++; $display("FAIL step_err_%0d got %h want 0008", k, err_last);
         end
         @(negedge clk);
         total++;
         if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune)) begin
            bad++;
            $display("FAIL step_early_%0d got %h want %h",
                     k, {pdm_hi_val, pdm_lo_val}, 24'(m_tune));
         end
         @(negedge clk);
         model_sample(2040);
         total++;
         if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune)) begin
            bad++;
            $display("FAIL step_tune_%0d got %h want %h",
                     k, {pdm_hi_val, pdm_lo_val}, 24'(m_tune));
         end
      end
   endtask

   task automatic test_saturation();
      ctl_kp_sh = 4'd4;
      ctl_ki_sh = 4'd4;
      do_preset(24'hFFFFF0);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'hFFFFF0) begin
         bad++;
         $display("FAIL preset_tune got %h want fffff0", {pdm_hi_val, pdm_lo_val});
      end
      sample(0);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune) ||
          err_last !== 16'(m_err)) begin
         bad++;
         $display("FAIL sat_hi got %h err %h want %h %h",
                  {pdm_hi_val, pdm_lo_val}, err_last, 24'(m_tune), 16'(m_err));
      end
      do_preset(24'h000000);
      sample(4000);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune) ||
          err_last !== 16'(m_err)) begin
         bad++;
         $display("FAIL sat_lo got %h err %h want %h %h",
                  {pdm_hi_val, pdm_lo_val}, err_last, 24'(m_tune), 16'(m_err));
      end
   endtask

   task automatic test_back_to_back();
      do_preset(24'h800000);
      ctl_kp_sh = 4'd2;
      ctl_ki_sh = 4'd3;
      @(negedge clk);
      cap_val = 16'd2030; cap_stb = 1'b1;
      @(negedge clk);
      cap_val = 16'd2000; cap_stb = 1'b1;
      @(negedge clk);
      cap_stb = 1'b0;
      total++;
      if (sample_miss !== 1'b1) begin
         bad++; $display("FAIL b2b_miss got %b want 1", sample_miss);
      end
      @(negedge clk);
      total++;
      if (sample_miss !== 1'b0) begin
         bad++; $display("FAIL b2b_miss_len got %b want 0", sample_miss);
      end
      @(negedge clk);
      model_sample(2030);
      repeat (4) @(negedge clk);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune) ||
          err_last !== 16'(m_err)) begin
         bad++;
         $display("FAIL b2b_tune got %h err %h want %h %h",
                  {pdm_hi_val, pdm_lo_val}, err_last, 24'(m_tune), 16'(m_err));
      end
   endtask

   task automatic test_relock();
      do_preset(24'h800000);
      ctl_kp_sh = 4'($urandom_range(0, 3));
      ctl_ki_sh = 4'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) sample(2048);
      total++;
      if (locked !== 1'b1) begin
         bad++; $display("FAIL relock_first got %b want 1", locked);
      end
      sample(2052);
      total++;
      if (locked !== 1'b0 || {pdm_hi_val, pdm_lo_val} !== 24'(m_tune)) begin
         bad++;
         $display("FAIL unlock got lock %b tune %h want 0 %h",
                  locked, {pdm_hi_val, pdm_lo_val}, 24'(m_tune));
      end
      for (int i = 0; i < 16; i++) begin
         sample(2048);
         total++;
         if (locked !== (m_cnt == 16)) begin
            bad++;
            $display("FAIL relock_%0d got %b want %b", i, locked, (m_cnt == 16));
         end
      end
   endtask

   task automatic test_abort();
      longint keep;
      keep = m_tune;
      strobe(2000);
      ctl_en = 1'b0;
      #1;
      total++;
      if (pdm_oe !== 1'b1) begin
         bad++; $display("FAIL oe_early got %b want 1", pdm_oe);
      end
      @(negedge clk);
      m_cnt = 0;
      total++;
      if (pdm_oe !== 1'b0 || locked !== 1'b0) begin
         bad++; $display("FAIL abort_oe_lock got %b %b want 0 0", pdm_oe, locked);
      end
      repeat (4) @(negedge clk);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'(keep)) begin
         bad++;
         $display("FAIL abort_hold got %h want %h", {pdm_hi_val, pdm_lo_val}, 24'(keep));
      end
      ctl_en = 1'b1;
      strobe(2048);
      strobe(2000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'h800000 || pdm_oe !== 1'b0 ||
          locked !== 1'b0 || err_last !== 16'h0 || sample_miss !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst got %h %b %b %h %b want 800000 0 0 0000 0",
                  {pdm_hi_val, pdm_lo_val}, pdm_oe, locked, err_last, sample_miss);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      total++;
      if ({pdm_hi_val, pdm_lo_val} !== 24'h800000) begin
         bad++;
         $display("FAIL post_rst got %h want 800000", {pdm_hi_val, pdm_lo_val});
      end
   endtask

   task automatic test_random();
      strobe(2048);
      do_preset(24'h800000);
      for (int i = 0; i < 30; i++) begin
         int cap;
         ctl_kp_sh = 4'($urandom_range(0, 5));
         ctl_ki_sh = 4'($urandom_range(0, 5));
         if (i % 2 == 0) cap = 2048 + int'($urandom_range(0, 600)) - 300;
         else            cap = 2048 + int'($urandom_range(0, 4)) - 2;
         sample(cap);
         total++;
         if ({pdm_hi_val, pdm_lo_val} !== 24'(m_tune) ||
             err_last !== 16'(m_err) || locked !== (m_cnt == 16)) begin
            bad++;
            $display("FAIL rand_%0d cap %0d got %h %h %b want %h %h %b",
                     i, cap, {pdm_hi_val, pdm_lo_val}, err_last, locked,
                     24'(m_tune), 16'(m_err), (m_cnt == 16));
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_nominal();
      test_integ_step();
      test_saturation();
      test_back_to_back();
      test_relock();
      test_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
